// File: rtl/xor_comar_vec_if.sv
// xor_comar_vec_if: valid/ready bus carrying shares, masks and the shared result for xor_comar_vec
interface xor_comar_vec_if #(parameter int WIDTH = 8);
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] a;
  logic [2*WIDTH-1:0] b;
  logic [2*WIDTH-1:0] r_in;
  logic [4*WIDTH-1:0] r_mid;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] c;
  modport master (output in_valid, a, b, r_in, r_mid, out_ready, input in_ready, out_valid, c);
  modport slave (input in_valid, a, b, r_in, r_mid, out_ready, output in_ready, out_valid, c);
endinterface

// File: rtl/xor_comar_vec.sv
// xor_comar_vec: WIDTH-lane 2-share masked XOR (refresh, re-mask, fold) in a 2-stage valid/ready pipe; XOR_COMAR_ZEROIZE_EN zeroes idle data regs
module xor_comar_vec #(parameter int WIDTH = 8) (
  input logic            clk,
  input logic            rst,
  xor_comar_vec_if.slave bus
);
  localparam int W = WIDTH;
  logic         r_s1_v, r_s2_v;
  logic [4*W-1:0] r_s1;
  logic [5*W-1:0] r_s2;
  logic [W-1:0] w_m0, w_m1, w_m2, w_m3;
  logic [4*W-1:0] w_s1_d;
  logic [5*W-1:0] w_s2_d;
  logic         w_adv1, w_adv2, w_acc, w_mv;
  assign w_adv2 = !r_s2_v || bus.out_ready;
  assign w_adv1 = !r_s1_v || w_adv2;
  assign w_acc = bus.in_valid && w_adv1;
  assign w_mv = r_s1_v && w_adv2;
  assign bus.in_ready = w_adv1;
  assign bus.out_valid = r_s2_v;
  genvar i;
  for (i = 0; i < W; i++) begin : g_lane
    assign w_m0[i] = bus.r_mid[4*i];
    assign w_m1[i] = bus.r_mid[4*i+1];
    assign w_m2[i] = bus.r_mid[4*i+2];
    assign w_m3[i] = bus.r_mid[4*i+3];
  end
  // S1 = {a0, a1, b0, b1}; every share is refreshed on its own so no two shares meet before the register
  assign w_s1_d = {bus.a[W-1:0] ^ bus.r_in[W-1:0], bus.a[2*W-1:W] ^ bus.r_in[W-1:0],
                   bus.b[W-1:0] ^ bus.r_in[2*W-1:W], bus.b[2*W-1:W] ^ bus.r_in[2*W-1:W]};
  // S2 = {x0, x1, x2, x3, sum}; sum carries the re-mask bits so the fold stays balanced
  assign w_s2_d = {r_s1[4*W-1:3*W] ^ w_m0, r_s1[3*W-1:2*W] ^ w_m1,
                   r_s1[2*W-1:W] ^ w_m2, r_s1[W-1:0] ^ w_m3, w_m0 ^ w_m1 ^ w_m2 ^ w_m3};
  assign bus.c = {r_s2[W-1:0], r_s2[5*W-1:4*W] ^ r_s2[4*W-1:3*W] ^ r_s2[3*W-1:2*W] ^ r_s2[2*W-1:W]};
  // stage valid flags: a stage refills or empties whenever it is allowed to advance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
    end else begin
      if (w_adv1) r_s1_v <= bus.in_valid;
      if (w_adv2) r_s2_v <= r_s1_v;
    end
  end
`ifdef XOR_COMAR_ZEROIZE_EN
  // data regs: load on transfer, otherwise clear when the stage advances without a new word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_acc ? w_s1_d : w_adv1 ? '0 : r_s1;
      r_s2 <= w_mv ? w_s2_d : w_adv2 ? '0 : r_s2;
    end
  end
`else
  // data regs: load only on transfer so held words are never re-masked while stalled
  always_ff @(posedge clk) begin
    if (w_acc) r_s1 <= w_s1_d;
    if (w_mv) r_s2 <= w_s2_d;
  end
`endif
endmodule

// File: tb/tb_xor_comar_vec.sv
// tb_xor_comar_vec: directed + random checks of xor_comar_vec against a word-queue model (XOR_COMAR_ZEROIZE_EN adds c==0 checks)
module tb_xor_comar_vec;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  xor_comar_vec_if #(.WIDTH(W)) bus ();
  xor_comar_vec #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask

  // model: words in flight, each with its unshared result and the cycle it was accepted
  typedef struct {logic [W-1:0] x; int t;} ent_t;
  ent_t q[$];
  int cyc = 0;
  bit armed = 0;
  bit stall_prev = 0;
  logic [2*W-1:0] c_prev;
  bit exp_ov, exp_ir;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      armed = 1;
      stall_prev = 0;
    end else if (armed) begin
      exp_ov = q.size() > 0 && q[0].t <= cyc - 2;
      exp_ir = q.size() < 2 || bus.out_ready;
      chk("in_ready", bus.in_ready, exp_ir);
      chk("out_valid", bus.out_valid, exp_ov);
      if (exp_ov) chk("c_fold", bus.c[W-1:0] ^ bus.c[2*W-1:W], q[0].x);
      if (stall_prev) chk("c_hold", bus.c, c_prev);
`ifdef XOR_COMAR_ZEROIZE_EN
      if (!exp_ov) chk("c_zero", bus.c, 0);
`endif
      stall_prev = exp_ov && !bus.out_ready;
      c_prev = bus.c;
      if (exp_ov && bus.out_ready) void'(q.pop_front());
      if (bus.in_valid && exp_ir)
        q.push_back('{bus.a[W-1:0] ^ bus.a[2*W-1:W] ^ bus.b[W-1:0] ^ bus.b[2*W-1:W], cyc});
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2*W-1:0] a, input logic [2*W-1:0] b, input logic [2*W-1:0] ri,
                       input logic [4*W-1:0] rm);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.r_in = ri;
    bus.r_mid = rm;
  endtask

  task automatic drive_rand();
    drive(16'($urandom), 16'($urandom), 16'($urandom), $urandom);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = '0;
    bus.b = '0;
    bus.r_in = '0;
    bus.r_mid = '0;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    // a = 0x5A^0x3C = 0x66, b = 0xF0^0x0F = 0xFF, zero masks -> c = {0x00, 0x99}
    step();
    drive(16'h5A3C, 16'hF00F, 16'h0, 32'h0);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lat1_out_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("lat2_out_valid", bus.out_valid, 1);
    chk("c_0x99", bus.c, 16'h0099);
    // a=b=0, lane0 re-mask 1011 folds to 1 in both shares whatever r_in is
    for (int k = 0; k < 2; k++) begin
      step();
      drive(16'h0, 16'h0, 16'($urandom), 32'h0000000B);
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mask_c", bus.c, 16'h0101);
    end
    step();
    // back-to-back random words with out_ready held high
    for (int k = 0; k < 3000; k++) begin
      drive_rand();
      step();
    end
    // random valid and back-pressure
    for (int k = 0; k < 3000; k++) begin
      drive_rand();
      bus.in_valid = $urandom_range(0, 1) == 1;
      bus.out_ready = $urandom_range(0, 3) != 0;
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    // stall: fill two words (0xD9 then 0x0F) and hold out_ready low while masks change
    bus.out_ready = 1'b0;
    drive(16'h1234, 16'h00FF, 16'($urandom), $urandom);
    step();
    drive(16'hA5A5, 16'h0F00, 16'($urandom), $urandom);
    step();
    for (int k = 0; k < 5; k++) begin
      drive_rand();
      @(negedge clk);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_c_fold", bus.c[W-1:0] ^ bus.c[2*W-1:W], 8'hD9);
      step();
    end
    // release with a new word every cycle: pop, move and accept together
    bus.out_ready = 1'b1;
    drive_rand();
    @(negedge clk);
    chk("full_pop_in_ready", bus.in_ready, 1);
    chk("full_pop_out_valid", bus.out_valid, 1);
    chk("pop1_c_fold", bus.c[W-1:0] ^ bus.c[2*W-1:W], 8'hD9);
    step();
    drive_rand();
    @(negedge clk);
    chk("pop2_out_valid", bus.out_valid, 1);
    chk("pop2_c_fold", bus.c[W-1:0] ^ bus.c[2*W-1:W], 8'h0F);
    step();
    for (int k = 0; k < 4; k++) begin
      drive_rand();
      step();
    end
    // reset with two words in flight
    bus.out_ready = 1'b0;
    drive_rand();
    step();
    drive_rand();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
`ifdef XOR_COMAR_ZEROIZE_EN
    chk("midrst_c_zero", bus.c, 0);
`endif
    repeat (4) step();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d words left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
